// File: rtl/entrada_pin_pkg.sv
// Shared constants, state encoding and key classification for the keypad front end.
package entrada_pin_pkg;

  localparam logic [7:0] PIN_ESPERA   = 8'h00;
  localparam logic [3:0] TECLA_BORRAR = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIG1  = 2'd1,
    ST_ENVIO = 2'd2
  } estado_t;

  function automatic logic es_digito(input logic [3:0] tecla);
    return (tecla <= 4'd9);
  endfunction

endpackage

// File: rtl/entrada_pin_detector_flanco.sv
// Synchronizes an asynchronous level and emits a registered one-cycle pulse on its rising edge.
module detector_flanco #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulso
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("detector_flanco: SYNC_STAGES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   pulso_q, pulso_d;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], din};
    prev_d  = sync_q[SYNC_STAGES-1];
    pulso_d = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulso_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulso_q <= pulso_d;
    end
  end

  assign pulso = pulso_q;

endmodule

// File: rtl/entrada_pin.sv
// Keypad front end: collects two BCD digits and presents them on Pin for PIN_HOLD cycles.
// Optional partial-entry timeout is compiled in when ENTRADA_TIMEOUT_EN is defined.
module entrada_pin
  import entrada_pin_pkg::*;
#(
  parameter int PIN_HOLD    = 1,
  parameter int TIMEOUT     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Vehiculo,
  input  logic       Tecla_valida,
  input  logic [3:0] Tecla,
  output logic [7:0] Pin,
  output logic       Pin_valido,
  output logic [1:0] Digitos,
  output logic       Error
);

  if (PIN_HOLD < 1 || PIN_HOLD > 15 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_param
    $error("entrada_pin: PIN_HOLD must be 1..15 and TIMEOUT 2..255");
  end

  logic evento;

  detector_flanco #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_detector (
    .clk  (Clk),
    .rst_n(Reset),
    .din  (Tecla_valida),
    .pulso(evento)
  );

  estado_t    estado_q, estado_d;
  logic [3:0] d1_q, d1_d;
  logic [7:0] pin_q, pin_d;
  logic       pin_valido_q, pin_valido_d;
  logic [1:0] digitos_q, digitos_d;
  logic       error_q, error_d;
  logic [3:0] hold_q, hold_d;
  logic [7:0] codigo;

  assign codigo = {d1_q, Tecla};

`ifdef ENTRADA_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;
`endif

  always_comb begin
    estado_d     = estado_q;
    d1_d         = d1_q;
    pin_d        = pin_q;
    pin_valido_d = pin_valido_q;
    digitos_d    = digitos_q;
    error_d      = 1'b0;
    hold_d       = hold_q;
`ifdef ENTRADA_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif
    case (estado_q)
      ST_IDLE: begin
        if (evento && Vehiculo && es_digito(Tecla)) begin
          d1_d      = Tecla;
          digitos_d = 2'd1;
          estado_d  = ST_DIG1;
`ifdef ENTRADA_TIMEOUT_EN
          tmo_d     = 8'd0;
`endif
        end
      end
      ST_DIG1: begin
        // Losing the vehicle abandons the entry silently, ahead of any key or timeout.
        if (!Vehiculo) begin
          digitos_d = 2'd0;
          estado_d  = ST_IDLE;
        end else if (evento) begin
`ifdef ENTRADA_TIMEOUT_EN
          tmo_d = 8'd0;
`endif
          if (es_digito(Tecla)) begin
            digitos_d = 2'd0;
            if (codigo == PIN_ESPERA) begin
              error_d  = 1'b1;
              estado_d = ST_IDLE;
            end else begin
              pin_d        = codigo;
              pin_valido_d = 1'b1;
              hold_d       = 4'(PIN_HOLD - 1);
              estado_d     = ST_ENVIO;
            end
          end else if (Tecla == TECLA_BORRAR) begin
            digitos_d = 2'd0;
            estado_d  = ST_IDLE;
          end
        end
`ifdef ENTRADA_TIMEOUT_EN
        else if (tmo_q == 8'(TIMEOUT - 1)) begin
          error_d   = 1'b1;
          digitos_d = 2'd0;
          estado_d  = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
      ST_ENVIO: begin
        if (hold_q == 4'd0) begin
          pin_d        = PIN_ESPERA;
          pin_valido_d = 1'b0;
          estado_d     = ST_IDLE;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      default: estado_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      estado_q     <= ST_IDLE;
      d1_q         <= 4'd0;
      pin_q        <= PIN_ESPERA;
      pin_valido_q <= 1'b0;
      digitos_q    <= 2'd0;
      error_q      <= 1'b0;
      hold_q       <= 4'd0;
`ifdef ENTRADA_TIMEOUT_EN
      tmo_q        <= 8'd0;
`endif
    end else begin
      estado_q     <= estado_d;
      d1_q         <= d1_d;
      pin_q        <= pin_d;
      pin_valido_q <= pin_valido_d;
      digitos_q    <= digitos_d;
      error_q      <= error_d;
      hold_q       <= hold_d;
`ifdef ENTRADA_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign Pin        = pin_q;
  assign Pin_valido = pin_valido_q;
  assign Digitos    = digitos_q;
  assign Error      = error_q;

endmodule

// File: tb/tb_entrada_pin.sv
// Self-checking bench for entrada_pin: directed table, corner sequences and randomized keypresses.
module tb_entrada_pin;
  import entrada_pin_pkg::*;

  localparam int H   = 3;
  localparam int TMO = 16;
`ifdef ENTRADA_TIMEOUT_EN
  localparam int TMO_EN = 1;
`else
  localparam int TMO_EN = 0;
`endif
  // Raw strobe sampled at edge 1 -> event after edge 3 -> Pin valid after edge 4.
  localparam int FIRST_VALID = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Vehiculo = 1'b0;
  logic       Tecla_valida = 1'b0;
  logic [3:0] Tecla = 4'd0;
  logic [7:0] Pin;
  logic       Pin_valido;
  logic [1:0] Digitos;
  logic       Error;

  entrada_pin #(
    .PIN_HOLD   (H),
    .TIMEOUT    (TMO),
    .SYNC_STAGES(2)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Vehiculo    (Vehiculo),
    .Tecla_valida(Tecla_valida),
    .Tecla       (Tecla),
    .Pin         (Pin),
    .Pin_valido  (Pin_valido),
    .Digitos     (Digitos),
    .Error       (Error)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  int         obs_err, obs_err_at, obs_nv, obs_first, obs_stray;
  logic [7:0] obs_pin;
  logic [1:0] obs_dig;

  typedef struct {
    logic       veh;
    logic [3:0] key;
    int         dig;
    int         err;
    int         nv;
    int         pin;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // pat bit j is the raw strobe level sampled at edge j+1; one observation per cycle.
  task automatic drive(input logic veh, input logic [3:0] key, input logic [63:0] pat, input int n);
    logic [63:0] pv;
    obs_err = 0; obs_err_at = -1; obs_nv = 0; obs_first = -1; obs_stray = 0; obs_pin = 8'h00;
    @(posedge Clk); #1;
    Vehiculo = veh; Tecla = key; Tecla_valida = pat[0];
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      if (Error) begin
        obs_err++;
        if (obs_err_at < 0) obs_err_at = i;
      end
      if (Pin_valido) begin
        obs_nv++;
        obs_pin = Pin;
        if (obs_first < 0) obs_first = i;
      end else if (Pin != PIN_ESPERA) begin
        obs_stray++;
      end
      obs_dig = Digitos;
      @(posedge Clk); #1;
      pv = pat >> (i + 1);
      Tecla_valida = pv[0];
    end
  endtask

  task automatic press(input logic veh, input logic [3:0] key, input int hi, input int lo);
    logic [63:0] pat;
    pat = (64'd1 << hi) - 64'd1;
    drive(veh, key, pat, hi + lo);
  endtask

  task automatic expect_txn(input string tag, input int dig, input int err, input int nv, input int pin);
    check({tag, "_digitos"}, int'(obs_dig), dig);
    check({tag, "_error"}, obs_err, err);
    check({tag, "_valid_cycles"}, obs_nv, nv);
    check({tag, "_stray_pin"}, obs_stray, 0);
    if (nv > 0) begin
      check({tag, "_pin"}, int'(obs_pin), pin);
      check({tag, "_latency"}, obs_first, FIRST_VALID);
    end
    $display("txn %s: Vehiculo=%0b Tecla=%0h Digitos=%0d errors=%0d valid=%0d pin=%02h",
             tag, Vehiculo, Tecla, obs_dig, obs_err, obs_nv, obs_pin);
  endtask

  // Transaction-level reference: what one completed keypress does to the entry in progress.
  logic       m_have;
  logic [3:0] m_d1;

  task automatic model_key(input logic veh, input logic [3:0] key,
                           output int dig, output int err, output int nv, output int pin);
    int code;
    err = 0; nv = 0; pin = 0;
    if (m_have) begin
      if (!veh) m_have = 1'b0;
      else if (key <= 4'd9) begin
        code = int'(m_d1) * 16 + int'(key);
        m_have = 1'b0;
        if (code == 0) err = 1;
        else begin nv = H; pin = code; end
      end else if (key == 4'hA) m_have = 1'b0;
    end else if (veh && key <= 4'd9) begin
      m_have = 1'b1;
      m_d1 = key;
    end
    dig = m_have ? 1 : 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ok;
    int e_dig, e_err, e_nv, e_pin;
    logic       r_veh;
    logic [3:0] r_key;

    tbl[0]  = '{1'b1, 4'h0, 1, 0, 0, 8'h00};
    tbl[1]  = '{1'b1, 4'h8, 0, 0, H, 8'h08};
    tbl[2]  = '{1'b1, 4'h0, 1, 0, 0, 8'h00};
    tbl[3]  = '{1'b1, 4'h0, 0, 1, 0, 8'h00};
    tbl[4]  = '{1'b1, 4'h1, 1, 0, 0, 8'h00};
    tbl[5]  = '{1'b1, 4'hA, 0, 0, 0, 8'h00};
    tbl[6]  = '{1'b1, 4'h2, 1, 0, 0, 8'h00};
    tbl[7]  = '{1'b1, 4'h3, 0, 0, H, 8'h23};
    tbl[8]  = '{1'b0, 4'h5, 0, 0, 0, 8'h00};
    tbl[9]  = '{1'b1, 4'h5, 1, 0, 0, 8'h00};
    tbl[10] = '{1'b0, 4'h5, 0, 0, 0, 8'h00};
    tbl[11] = '{1'b1, 4'hC, 0, 0, 0, 8'h00};
    tbl[12] = '{1'b1, 4'h7, 1, 0, 0, 8'h00};
    tbl[13] = '{1'b1, 4'hB, 1, 0, 0, 8'h00};
    tbl[14] = '{1'b1, 4'h6, 0, 0, H, 8'h76};

    // Reset state
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("reset_pin", int'(Pin), 0);
    check("reset_pin_valido", int'(Pin_valido), 0);
    check("reset_digitos", int'(Digitos), 0);
    check("reset_error", int'(Error), 0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    repeat (2) @(posedge Clk);

    for (int i = 0; i < 15; i++) begin
      press(tbl[i].veh, tbl[i].key, 4, 5);
      expect_txn($sformatf("tbl%0d", i), tbl[i].dig, tbl[i].err, tbl[i].nv, tbl[i].pin);
    end

    // A second event landing in the last ENVIO cycle must be discarded.
    press(1'b1, 4'h1, 4, 4);
    expect_txn("envio_d1", 1, 0, 0, 0);
    drive(1'b1, 4'h2, 64'h7B, 14);
    expect_txn("envio_discard", 0, 0, H, 8'h12);

    // Key held 40 cycles yields a single event.
    press(1'b1, 4'h9, 40, 4);
    expect_txn("held40", TMO_EN ? 0 : 1, TMO_EN, 0, 0);
    check("held40_error_cycle", obs_err_at, TMO_EN ? 4 + TMO : -1);
    press(1'b1, 4'hA, 4, 4);
    expect_txn("held40_clear", 0, 0, 0, 0);

    // Partial entry left idle.
    press(1'b1, 4'h4, 4, 20);
    expect_txn("timeout", TMO_EN ? 0 : 1, TMO_EN, 0, 0);
    check("timeout_error_cycle", obs_err_at, TMO_EN ? 4 + TMO : -1);
    press(1'b1, 4'hA, 4, 4);
    expect_txn("timeout_clear", 0, 0, 0, 0);

    // Asynchronous reset while Pin=8'h08 is being presented.
    press(1'b1, 4'h0, 4, 4);
    expect_txn("rst_d1", 1, 0, 0, 0);
    @(posedge Clk); #1;
    Tecla = 4'h8; Tecla_valida = 1'b1;
    ok = 0;
    for (int i = 0; i < 20 && ok == 0; i++) begin
      @(negedge Clk);
      if (Pin_valido) ok = 1;
    end
    check("rst_reach_envio", ok, 1);
    check("rst_pin_before", int'(Pin), 8'h08);
    #2; Reset = 1'b0; #1;
    check("rst_async_pin", int'(Pin), 0);
    check("rst_async_pin_valido", int'(Pin_valido), 0);
    check("rst_async_digitos", int'(Digitos), 0);
    @(posedge Clk); #1;
    Tecla_valida = 1'b0;
    repeat (3) @(posedge Clk);
    #1; Reset = 1'b1;
    repeat (6) @(posedge Clk);
    #1;
    check("rst_after_digitos", int'(Digitos), 0);
    check("rst_after_pin", int'(Pin), 0);
    $display("txn rst_mid_envio: Pin=%02h Pin_valido=%0b Digitos=%0d", Pin, Pin_valido, Digitos);

    // Randomized keypresses against the transaction-level model.
    m_have = 1'b0;
    m_d1   = 4'd0;
    for (int t = 0; t < 60; t++) begin
      r_veh = ($urandom_range(0, 99) < 85);
      r_key = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      model_key(r_veh, r_key, e_dig, e_err, e_nv, e_pin);
      press(r_veh, r_key, $urandom_range(4, 6), $urandom_range(4, 5));
      expect_txn($sformatf("rnd%0d", t), e_dig, e_err, e_nv, e_pin);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
